// File: rtl/peripheral_noc_pkg.sv
// Shared types and helpers for the NoC router output arbitration logic.
package peripheral_noc_pkg;

  // Arbiter ownership state: IDLE has no owner, LOCKED holds a one-hot grant.
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Widest request vector the index helper can decode.
  localparam int unsigned MAX_INPUTS = 32;

  // Index of the set bit of a one-hot vector (0 when the vector is empty).
  function automatic int unsigned onehot2idx(input logic [MAX_INPUTS-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_INPUTS; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/peripheral_noc_arb_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module peripheral_noc_arb_rr #(
  parameter int N = 5,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Scan N positions starting at ptr modulo N and grant the first request seen.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/peripheral_noc_router_output_arbiter.sv
// Wormhole output arbiter: round-robin grant held from head to last flit,
// single registered output stage with full-throughput backpressure.
module peripheral_noc_router_output_arbiter
  import peripheral_noc_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int INPUTS     = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [INPUTS-1:0][FLIT_WIDTH-1:0]  in_flit,
  input  logic [INPUTS-1:0]                  in_last,
  input  logic [INPUTS-1:0]                  in_valid,
  output logic [INPUTS-1:0]                  in_ready,
  output logic [FLIT_WIDTH-1:0]              out_flit,
  output logic                               out_last,
  output logic                               out_valid,
  input  logic                               out_ready
);

  // With one input the pointer degenerates to a constant 1-bit zero.
  localparam int PTR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  arb_state_t                state_q;
  logic [INPUTS-1:0]         gnt_q;
  logic [PTR_W-1:0]          ptr_q;
  logic [PTR_W-1:0]          ptr_d;
  logic [INPUTS-1:0]         rr_gnt;

  logic [FLIT_WIDTH-1:0]     out_flit_q;
  logic                      out_last_q;
  logic                      out_valid_q;

  logic                      out_free;
  logic                      xfer;
  logic [FLIT_WIDTH-1:0]     sel_flit;
  logic                      sel_last;

  peripheral_noc_arb_rr #(
    .N (INPUTS)
  ) u_rr (
    .req (in_valid),
    .ptr (ptr_q),
    .gnt (rr_gnt)
  );

  // The output register can take a flit when empty or when draining this cycle.
  assign out_free = ~out_valid_q | out_ready;
  assign in_ready = (state_q == ARB_LOCKED) ? (gnt_q & {INPUTS{out_free}}) : '0;
  assign xfer     = |(in_valid & in_ready);

  // Route the owner's flit; gnt_q is one-hot so an OR-reduction mux suffices.
  always_comb begin
    sel_flit = '0;
    sel_last = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      if (gnt_q[i]) begin
        sel_flit = sel_flit | in_flit[i];
        sel_last = sel_last | in_last[i];
      end
    end
  end

  // Pointer moves one past the newly granted input (index helper covers up to 32 inputs).
  always_comb begin
    ptr_d = PTR_W'((onehot2idx(MAX_INPUTS'(rr_gnt)) + 1) % INPUTS);
  end

  // Ownership FSM: grant in IDLE, hold through the packet, release on the last flit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|in_valid) begin
            state_q <= ARB_LOCKED;
            gnt_q   <= rr_gnt;
            ptr_q   <= ptr_d;
          end
        end
        ARB_LOCKED: begin
          if (xfer && sel_last) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  // Output stage: load on transfer, empty when drained without a replacement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_flit_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (xfer) begin
      out_flit_q  <= sel_flit;
      out_last_q  <= sel_last;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_flit  = out_flit_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_peripheral_noc_router_output_arbiter.sv
// Scoreboard bench for the wormhole output arbiter (5 inputs, 32-bit flits).
module tb_peripheral_noc_router_output_arbiter;

  localparam int NI = 5;
  localparam int FW = 32;

  logic                   clk;
  logic                   rst;
  logic [NI-1:0][FW-1:0]  in_flit;
  logic [NI-1:0]          in_last;
  logic [NI-1:0]          in_valid;
  logic [NI-1:0]          in_ready;
  logic [FW-1:0]          out_flit;
  logic                   out_last;
  logic                   out_valid;
  logic                   out_ready;

  peripheral_noc_router_output_arbiter #(
    .FLIT_WIDTH (FW),
    .INPUTS     (NI)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Per-input flit sources {last, flit}, expected output order, driver knobs.
  logic [32:0] mem [NI][32];
  int          head [NI];
  int          tail [NI];
  logic [32:0] expq [$];
  logic [NI-1:0] pause;
  logic [NI-1:0] acc;
  logic          or_knob;

  task automatic add(input int i, input logic [31:0] f, input logic l);
    mem[i][tail[i]] = {l, f};
    tail[i]++;
    expq.push_back({l, f});
  endtask

  task automatic clear_src();
    for (int i = 0; i < NI; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    pause = '0;
    expq.delete();
  endtask

  // Handshakes are sampled mid-cycle, when every DUT signal is settled.
  always @(negedge clk) acc = in_valid & in_ready;

  // Drive inputs just after each rising edge from the source tables.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NI; i++) begin
      if (acc[i]) head[i]++;
      if (head[i] < tail[i]) begin
        in_flit[i]  = mem[i][head[i]][31:0];
        in_last[i]  = mem[i][head[i]][32];
        in_valid[i] = !pause[i];
      end else begin
        in_valid[i] = 1'b0;
      end
    end
    out_ready = or_knob;
  end

  // Output monitor: every accepted output flit is compared to the scoreboard.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("mon_extra", 64'(expq.size()), 64'd1);
      end else begin
        logic [32:0] e;
        e = expq.pop_front();
        chk("mon_flit", {31'b0, out_last, out_flit}, {31'b0, e});
      end
    end
  end

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(expq.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_src();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b0;
    in_flit  = '0;
    in_last  = '0;
    in_valid = '0;
    out_ready = 1'b1;
    or_knob  = 1'b1;
    acc      = '0;
    clear_src();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_out_flit",  64'(out_flit),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    rst = 1'b1;

    // Single input, three-flit packet on input 2.
    add(2, 32'hA0, 1'b0);
    add(2, 32'hA1, 1'b0);
    add(2, 32'hA2, 1'b1);
    @(negedge clk);
    chk("t1_rdy_idle", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("t1_rdy_n1", 64'(in_ready), 64'h04);
    chk("t1_ov_n1", 64'(out_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_ov_burst", 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    chk("t1_ov_end", 64'(out_valid), 64'd0);
    wait_drain("t1_drain");

    // Inputs 1 and 3 from reset, then simultaneous re-request with pointer wrap.
    do_reset();
    add(1, 32'hB0, 1'b0);
    add(1, 32'hB1, 1'b1);
    add(3, 32'hC0, 1'b0);
    add(3, 32'hC1, 1'b1);
    @(negedge clk);
    chk("t2_rdy_n0", 64'(in_ready), 64'h00);
    @(negedge clk);
    chk("t2_rdy_n1", 64'(in_ready), 64'h02);
    @(negedge clk);
    chk("t2_rdy_n2", 64'(in_ready), 64'h02);
    @(negedge clk);
    chk("t2_rdy_gap", 64'(in_ready), 64'h00);
    @(negedge clk);
    chk("t2_rdy_n4", 64'(in_ready), 64'h08);
    @(negedge clk);
    chk("t2_rdy_n5", 64'(in_ready), 64'h08);
    wait_drain("t2_drain_a");
    add(1, 32'hD0, 1'b0);
    add(1, 32'hD1, 1'b1);
    add(3, 32'hE0, 1'b0);
    add(3, 32'hE1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t2_wrap_rdy", 64'(in_ready), 64'h02);
    wait_drain("t2_drain_b");

    // Wormhole hold: owner pauses three cycles while input 0 requests.
    add(2, 32'hF0, 1'b0);
    add(2, 32'hF1, 1'b0);
    add(2, 32'hF2, 1'b0);
    add(2, 32'hF3, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("wh_rdy_head", 64'(in_ready), 64'h04);
    pause[2] = 1'b1;
    add(0, 32'h60, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wh_hold_rdy", 64'(in_ready), 64'h04);
    end
    pause[2] = 1'b0;
    wait_drain("wh_drain");

    // Backpressure: out_ready low for four cycles with the register full.
    add(4, 32'h70, 1'b0);
    add(4, 32'h71, 1'b0);
    add(4, 32'h72, 1'b0);
    add(4, 32'h73, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("bp_rdy_head", 64'(in_ready), 64'h10);
    or_knob = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_ov", 64'(out_valid), 64'd1);
      chk("bp_flit", 64'(out_flit), 64'h70);
      chk("bp_rdy", 64'(in_ready), 64'h00);
    end
    or_knob = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", 64'(in_ready), 64'h10);
    @(negedge clk);
    chk("bp_nobubble_ov", 64'(out_valid), 64'd1);
    chk("bp_nobubble_flit", 64'(out_flit), 64'h71);
    wait_drain("bp_drain");

    // Back-to-back single-flit packets from inputs 0 and 1 alternate.
    add(0, 32'h80, 1'b1);
    add(1, 32'h90, 1'b1);
    add(0, 32'h81, 1'b1);
    add(1, 32'h91, 1'b1);
    add(0, 32'h82, 1'b1);
    add(1, 32'h92, 1'b1);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("sf_ov_pattern", 64'(out_valid), (k % 2 == 0) ? 64'd1 : 64'd0);
    end
    wait_drain("sf_drain");

    // Mid-packet asynchronous reset, then pointer must restart at 0.
    add(3, 32'hC8, 1'b0);
    add(3, 32'hC9, 1'b0);
    add(3, 32'hCA, 1'b0);
    add(3, 32'hCB, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("mr_rdy_locked", 64'(in_ready), 64'h08);
    @(negedge clk);
    chk("mr_ov_locked", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b0;
    clear_src();
    #1;
    chk("mr_async_ov",  64'(out_valid), 64'd0);
    chk("mr_async_rdy", 64'(in_ready),  64'd0);
    chk("mr_async_flit", 64'(out_flit), 64'd0);
    @(negedge clk);
    chk("mr_hold_ov", 64'(out_valid), 64'd0);
    rst = 1'b1;
    add(2, 32'hD8, 1'b0);
    add(2, 32'hD9, 1'b1);
    add(4, 32'hE8, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("mr_ptr_zero_rdy", 64'(in_ready), 64'h04);
    wait_drain("mr_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
